// File: rtl/fetch_issue.sv
// Fetch/issue front end: one outstanding imem request, FIFO of {instr, pc} toward decode, redirect flush.
// Optional macro FETCH_ALIGN_CHK_EN: odd redirect targets raise a sticky err and halt fetch.
module fetch_issue #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       INSTR_W   = 16,
  parameter int unsigned       BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         imem_req_o,
  output logic [ADDR_W-1:0]            imem_addr_o,
  input  logic                         imem_ack_i,
  input  logic [INSTR_W-1:0]           imem_rdata_i,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_pc_i,
  output logic                         dec_valid_o,
  input  logic                         dec_ready_i,
  output logic [INSTR_W-1:0]           dec_instr_o,
  output logic [ADDR_W-1:0]            dec_pc_o,
  output logic [ADDR_W-1:0]            dec_pc_next_o,
  output logic                         halted_o,
  output logic [$clog2(BUF_DEPTH):0]   buf_count_o,
  output logic                         err_o
);

  localparam int unsigned       PTR_W  = $clog2(BUF_DEPTH);
  localparam int unsigned       CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL   = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(2);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP, S_HALT} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic                hpend_q, hpend_d;
  logic                halted_q;
  logic                started_q;
  logic                req;
  logic                push;
  logic                pop;
  logic                misalign;
  logic [ADDR_W-1:0]   redir_pc;
  logic                is_halt_op;

  logic [INSTR_W-1:0]  buf_instr_q [BUF_DEPTH];
  logic [ADDR_W-1:0]   buf_pc_q    [BUF_DEPTH];

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q;

  assign misalign = redirect_pc_i[0];
  assign redir_pc = redirect_pc_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (redirect_i && misalign) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign misalign = 1'b0;
  assign redir_pc = redirect_pc_i & ~ADDR_W'(1);
  assign err_o    = 1'b0;
`endif

  assign is_halt_op = (imem_rdata_i[INSTR_W-1 -: 5] == 5'b0_0000);
  assign pop        = dec_valid_o && dec_ready_i;

  // started_q keeps imem_req low while reset is asserted even though state resets to RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    hpend_d = hpend_q;
    req     = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = misalign ? S_HALT : S_RUN;
        end else if (started_q && (cnt_q < FULL)) begin
          req     = 1'b1;
          addr_d  = pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (redirect_i) begin
          pc_d = redir_pc;
          if (imem_ack_i) begin
            state_d = misalign ? S_HALT : S_RUN;
          end else begin
            state_d = S_DROP;
            hpend_d = misalign;
          end
        end else if (imem_ack_i) begin
          push    = 1'b1;
          pc_d    = pc_q + PC_INC;
          state_d = is_halt_op ? S_HALT : S_RUN;
        end
      end
      S_DROP: begin
        req = 1'b1;
        if (redirect_i) begin
          pc_d    = redir_pc;
          hpend_d = misalign;
        end
        if (imem_ack_i) begin
          state_d = hpend_d ? S_HALT : S_RUN;
        end
      end
      S_HALT: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = misalign ? S_HALT : S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // A redirect flushes everything except a head transfer completing this same cycle.
  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_i) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_RUN;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      hpend_q   <= 1'b0;
      halted_q  <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      hpend_q   <= hpend_d;
      halted_q  <= (state_d == S_HALT) && (cnt_d == '0);
      started_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata_i;
      buf_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = (state_q == S_RUN) ? pc_q : addr_q;
  assign dec_valid_o   = (cnt_q != '0);
  assign dec_instr_o   = dec_valid_o ? buf_instr_q[rd_ptr_q] : '0;
  assign dec_pc_o      = dec_valid_o ? buf_pc_q[rd_ptr_q] : '0;
  assign dec_pc_next_o = dec_valid_o ? (buf_pc_q[rd_ptr_q] + PC_INC) : '0;
  assign halted_o      = halted_q;
  assign buf_count_o   = cnt_q;

endmodule

// File: tb/tb_fetch_issue.sv
// Randomized bench: memory responder + program-level model feed a scoreboard checked by a decode monitor.
module tb_fetch_issue;

`ifdef FETCH_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  localparam int NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic [15:0] dec_pc_next;
  logic        halted;
  logic [1:0]  buf_count;
  logic        err;

  always #5 clk = ~clk;

  fetch_issue dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .dec_valid_o   (dec_valid),
    .dec_ready_i   (dec_ready),
    .dec_instr_o   (dec_instr),
    .dec_pc_o      (dec_pc),
    .dec_pc_next_o (dec_pc_next),
    .halted_o      (halted),
    .buf_count_o   (buf_count),
    .err_o         (err)
  );

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  logic [15:0] mem [0:255];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Program-level model: next fetch address, in-flight request, stopped fetch.
  bit          stopped     = 1'b0;
  bit          outstanding = 1'b0;
  bit          stale       = 1'b0;
  bit          err_exp     = 1'b0;
  bit          mon_on      = 1'b0;
  logic [15:0] mpc         = 16'h0000;
  logic [15:0] out_addr    = 16'h0000;
  int          lat         = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode-side monitor: pops the scoreboard on every accepted head.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        #2;
        check("dec_valid", 32'(dec_valid), 32'(exp_q.size() != 0));
        check("buf_count", 32'(buf_count), 32'(exp_q.size()));
        check("halted", 32'(halted), 32'(stopped && !outstanding && (exp_q.size() == 0)));
        check("err", 32'(err), 32'(err_exp));
        if (dec_valid && dec_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_unexpected: got pc %0h expected no issue at %0t", dec_pc, $time);
          end else begin
            e = exp_q.pop_front();
            check("dec_pc", 32'(dec_pc), 32'(e.pc));
            check("dec_instr", 32'(dec_instr), 32'(e.instr));
            check("dec_pc_next", 32'(dec_pc_next), 32'(16'(e.pc + 16'd2)));
          end
        end
      end
    end
  end

  initial begin
    int  ready_pct;
    int  hold;
    int  rp;
    bit  new_req;
    bit  exp_req;
    bit  acked;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 11) == 0) mem[i][15:11] = 5'b0_0000;
      else if (mem[i][15:11] == 5'b0_0000) mem[i][15] = 1'b1;
    end

    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 16'h0000;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    dec_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(dec_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(buf_count), 32'd0);
    check("rst_instr", 32'(dec_instr), 32'd0);
    check("rst_pc", 32'(dec_pc), 32'd0);
    check("rst_pc_next", 32'(dec_pc_next), 32'd0);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    ready_pct = 70;
    hold      = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc % 150 == 0) begin
        case ($urandom_range(0, 2))
          0:       ready_pct = 25;
          1:       ready_pct = 70;
          default: ready_pct = 100;
        endcase
      end
      if (hold == 0 && $urandom_range(0, 99) < 2) hold = 10;
      if (hold > 0) begin
        dec_ready = 1'b0;
        hold--;
      end else begin
        dec_ready = ($urandom_range(0, 99) < ready_pct);
      end
      rp          = (stopped && exp_q.size() == 0) ? 25 : 4;
      redirect    = ($urandom_range(0, 99) < rp);
      redirect_pc = 16'($urandom);
      if ($urandom_range(0, 3) != 0) redirect_pc[0] = 1'b0;
      if (outstanding && lat == 1) begin
        imem_ack   = 1'b1;
        imem_rdata = mem[out_addr[8:1]];
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
      end

      #1;
      new_req = 1'b0;
      if (outstanding) begin
        check("req_hold", 32'(imem_req), 32'd1);
        check("addr_hold", 32'(imem_addr), 32'(out_addr));
      end else begin
        exp_req = !stopped && (exp_q.size() < 2) && !redirect;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) begin
          check("imem_addr", 32'(imem_addr), 32'(mpc));
          new_req = 1'b1;
        end
      end

      #2;
      acked = imem_ack && outstanding;
      if (redirect) begin
        exp_q.delete();
        if (ALIGN && redirect_pc[0]) begin
          err_exp = 1'b1;
          stopped = 1'b1;
          mpc     = redirect_pc;
        end else begin
          stopped = 1'b0;
          mpc     = {redirect_pc[15:1], 1'b0};
        end
        if (acked) begin
          outstanding = 1'b0;
          stale       = 1'b0;
        end else if (outstanding) begin
          stale = 1'b1;
        end
      end else if (acked) begin
        outstanding = 1'b0;
        if (!stale) begin
          exp_q.push_back('{pc: out_addr, instr: imem_rdata});
          mpc = out_addr + 16'd2;
          if (imem_rdata[15:11] == 5'b0_0000) stopped = 1'b1;
        end
        stale = 1'b0;
      end
      if (new_req) begin
        outstanding = 1'b1;
        stale       = 1'b0;
        out_addr    = mpc;
        lat         = $urandom_range(1, 3);
      end else if (outstanding) begin
        lat--;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
